// File: rtl/fl_narrower.sv
// rtl/fl_narrower.sv - FrameLink width narrower, one RX word emitted as RATIO (or fewer) TX slices
//
// Ports:
//   CLK, RESET                         single rising-edge clock, synchronous active-high reset
//   RX_DATA, RX_DREM                   input word and index of its last valid byte (valid with EOP)
//   RX_SOF_N/EOF_N/SOP_N/EOP_N         active-low input delimiters
//   RX_SRC_RDY_N / RX_DST_RDY_N        input handshake (active-low)
//   TX_DATA, TX_DREM                   output slice and index of its last valid byte
//   TX_SOF_N/EOF_N/SOP_N/EOP_N         active-low output delimiters
//   TX_SRC_RDY_N / TX_DST_RDY_N        output handshake (active-low)
module fl_narrower #(
    parameter int RX_DATA_WIDTH = 64,
    parameter int TX_DATA_WIDTH = 16,
    localparam int RX_REM_W = $clog2(RX_DATA_WIDTH / 8),
    localparam int TX_REM_W = (TX_DATA_WIDTH > 8) ? $clog2(TX_DATA_WIDTH / 8) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [RX_DATA_WIDTH-1:0] RX_DATA,
    input  logic [RX_REM_W-1:0]      RX_DREM,
    input  logic                     RX_SOF_N,
    input  logic                     RX_EOF_N,
    input  logic                     RX_SOP_N,
    input  logic                     RX_EOP_N,
    input  logic                     RX_SRC_RDY_N,
    output logic                     RX_DST_RDY_N,
    output logic [TX_DATA_WIDTH-1:0] TX_DATA,
    output logic [TX_REM_W-1:0]      TX_DREM,
    output logic                     TX_SOF_N,
    output logic                     TX_EOF_N,
    output logic                     TX_SOP_N,
    output logic                     TX_EOP_N,
    output logic                     TX_SRC_RDY_N,
    input  logic                     TX_DST_RDY_N
);

    localparam int RATIO    = RX_DATA_WIDTH / TX_DATA_WIDTH;
    localparam int CNT_W    = $clog2(RATIO);
    localparam int TX_BYTES = TX_DATA_WIDTH / 8;
    localparam int BSHIFT   = $clog2(TX_BYTES);
    localparam logic [RX_REM_W-1:0] BYTE_MASK = RX_REM_W'(TX_BYTES - 1);

    // Buffered RX word
    logic [RX_DATA_WIDTH-1:0] data_q, data_d;
    logic [RX_REM_W-1:0]      drem_q, drem_d;
    logic                     sof_q, sof_d;
    logic                     eof_q, eof_d;
    logic                     sop_q, sop_d;
    logic                     eop_q, eop_d;
    logic                     valid_q, valid_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [CNT_W-1:0]         last_slice;
    logic                     is_last;
    logic                     tx_xfer;
    logic                     rx_rdy;
    logic                     rx_xfer;
    logic                     out_en;

    always_comb begin
        // Slices above the one holding the last valid byte are skipped on an EOP word.
        last_slice = eop_q ? CNT_W'(drem_q >> BSHIFT) : CNT_W'(RATIO - 1);
        is_last    = (cnt_q == last_slice);
        out_en     = valid_q & ~RESET;
        tx_xfer    = out_en & ~TX_DST_RDY_N;
        // Accepting while the final slice leaves keeps the TX side gap-free.
        rx_rdy     = ~RESET & (~valid_q | (tx_xfer & is_last));
        rx_xfer    = rx_rdy & ~RX_SRC_RDY_N;

        data_d  = data_q;
        drem_d  = drem_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (rx_xfer) begin
            data_d  = RX_DATA;
            drem_d  = RX_DREM;
            sof_d   = ~RX_SOF_N;
            eof_d   = ~RX_EOF_N;
            sop_d   = ~RX_SOP_N;
            eop_d   = ~RX_EOP_N;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else if (tx_xfer) begin
            if (is_last) begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_q  <= '0;
            drem_q  <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            drem_q  <= drem_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by RESET so they go idle in the reset cycle itself,
    // not one edge later.
    assign RX_DST_RDY_N = ~rx_rdy;
    assign TX_SRC_RDY_N = ~out_en;
    assign TX_DATA      = out_en ? data_q[cnt_q*TX_DATA_WIDTH +: TX_DATA_WIDTH] : '0;
    assign TX_DREM      = ~out_en ? '0 :
                          (eop_q & is_last) ? TX_REM_W'(drem_q & BYTE_MASK) : '1;
    assign TX_SOF_N     = ~(out_en & sof_q & (cnt_q == '0));
    assign TX_SOP_N     = ~(out_en & sop_q & (cnt_q == '0));
    assign TX_EOF_N     = ~(out_en & eof_q & is_last);
    assign TX_EOP_N     = ~(out_en & eop_q & is_last);

endmodule
